alu_bit_serial_sequencer: RTL and testbench
===========================================

// Module: alu_bit_serial_sequencer
// PURPOSE
//  Initiator for the 1-bit ALU slice. Accepts one word operation per valid/ready request.
//  Drives the slice one bit per clock, LSB first, over WIDTH cycles.
//  Chains carry through a register and assembles result, overflow and zero flags.
//  Lets one shared slice execute full-width AND/OR/ADD/SUB/SLT/NOR at low area.
// PARAMETERS
//  WIDTH  64  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  req_valid   in   1      request present
//  req_ready   out  1      sequencer can accept (IDLE only)
//  req_op      in   3      0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6/7 reserved
//  req_a       in   WIDTH  operand A
//  req_b       in   WIDTH  operand B
//  alu_a       out  1      slice A bit
//  alu_b       out  1      slice B bit
//  alu_ainv    out  1      slice A-invert
//  alu_binv    out  1      slice B-invert
//  alu_op      out  2      slice mux: 00 AND, 01 OR, 10 SUM, 11 LESS
//  alu_cin     out  1      slice carry in
//  alu_less    out  1      slice Less input, tied 0
//  alu_o       in   1      slice result bit
//  alu_cout    in   1      slice carry out
//  alu_set     in   1      slice sum bit
//  alu_ovf     in   1      slice overflow (Cin^Cout)
//  rsp_valid   out  1      result available
//  rsp_ready   in   1      consumer accepts result
//  rsp_result  out  WIDTH  result word
//  rsp_ovf     out  1      signed overflow (ADD/SUB only, else 0)
//  rsp_zero    out  1      rsp_result == 0
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_ovf=0, rsp_zero=0.
//  - Reset also zeroes the bit counter, carry register and operand registers.
//  - Slice drive outputs are 0 while not in RUN.
//  FSM IDLE -> RUN on req_valid&&req_ready:
//  - latch A, B and op; cnt=0; carry=cin0 (1 for SUB/SLT, else 0).
//  RUN, each cycle:
//  - alu_a=A[cnt], alu_b=B[cnt]; ainv/binv/op from decode; alu_cin=carry.
//  - At the edge: shift alu_o into result MSB (shift right); carry<=alu_cout; cnt++.
//  RUN -> DONE at the edge where cnt==WIDTH-1; that bit's alu_ovf and alu_set are captured.
//  - rsp_valid is first high WIDTH cycles after the accept edge.
//  DONE: rsp_* held stable until rsp_valid&&rsp_ready; then -> IDLE.
//  - Next accept is possible one cycle later. Peak throughput is one op per WIDTH+2 cycles.
//  Decode (ainv, binv, op, cin0):
//  - AND 0,0,00,0;  OR 0,0,01,0;  ADD 0,0,10,0;  SUB 0,1,10,1;  NOR 1,1,00,0.
//  - SLT 0,1,10,1: result = {WIDTH-1 zeros, set_msb ^ ovf_msb}; rsp_ovf=0.
//  - Reserved 6/7: full WIDTH cycles still run; rsp_result=0, rsp_ovf=0, rsp_zero=1.
//  Flags: rsp_ovf = ovf_msb for ADD/SUB only. rsp_zero is computed on the final result word.
//  Boundaries:
//  - req_valid while busy is ignored (req_ready=0); no request is lost or duplicated.
//  - A new request is never accepted in the same cycle as the rsp handshake.
//  - Reset mid-RUN or in DONE: IDLE on the next cycle; any partial result is discarded, never emitted.
//  - Carry wraps naturally: the final cout is dropped, and result is modulo 2^WIDTH.
// STRUCTURE
//  Shared package alu_seq_pkg:
//  - req_op codes, slice alu_op encodings, FSM state enum (IDLE/RUN/DONE).
//  - $clog2(WIDTH) counter-width helper.
//  One sub-module alu_seq_decode: combinational op -> {ainv, binv, alu_op, cin0, is_slt, is_arith}.
//  Top level holds the FSM, counter, carry register, result shift register and flags.
// TESTING  (WIDTH=8, real slice instance attached)
//  1 ADD 8'h7F+8'h01 -> rsp_result=8'h80, rsp_ovf=1, rsp_zero=0, rsp_valid exactly 8 cycles after accept.
//  2 SUB 8'h05-8'h05 -> rsp_result=8'h00, rsp_zero=1, rsp_ovf=0; SUB 8'h80-8'h01 -> 8'h7F, rsp_ovf=1.
//  3 SLT 8'h80,8'h01 -> 8'h01; SLT 8'h7F,8'h80 -> 8'h00 (overflow-corrected); SLT 8'h03,8'h03 -> 8'h00, zero=1.
//  4 AND F0,3C -> 30; OR F0,0F -> FF; NOR F0,0F -> 00, zero=1; op 6 -> 00, ovf=0.
//  5 rsp_ready low 5 cycles in DONE -> rsp_* stable, req_ready=0, extra req_valid ignored.
//    Then handshake -> IDLE; back-to-back ops spaced 10 cycles.
//  6 rst pulsed at RUN cnt=3 -> next cycle req_ready=1, rsp_valid=0.
//    A following ADD 8'h01+8'h01 -> 8'h02 with no corruption.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: request opcodes,
// slice mux encodings, FSM states and the bit-counter width helper.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;

    localparam logic [1:0] SL_AND  = 2'b00;
    localparam logic [1:0] SL_OR   = 2'b01;
    localparam logic [1:0] SL_SUM  = 2'b10;
    localparam logic [1:0] SL_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to index 0..w-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/alu_bit_serial_sequencer_if.sv
// Request/response handshake bundle between a requester and the sequencer.
interface alu_bit_serial_sequencer_if #(parameter int WIDTH = 64);

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_ovf;
    logic             rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_zero
    );

endinterface

// File: rtl/alu_seq_decode.sv
// Maps a request opcode onto the slice controls and the flags the
// sequencer needs to post-process the assembled word.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op_i,
    output logic       ainv_o,
    output logic       binv_o,
    output logic [1:0] alu_op_o,
    output logic       cin0_o,
    output logic       is_slt_o,
    output logic       is_arith_o,
    output logic       is_rsvd_o
);

    // Opcode decode; reserved codes run as a harmless AND and are zeroed later.
    always_comb begin
        ainv_o     = 1'b0;
        binv_o     = 1'b0;
        alu_op_o   = SL_AND;
        cin0_o     = 1'b0;
        is_slt_o   = 1'b0;
        is_arith_o = 1'b0;
        is_rsvd_o  = 1'b0;
        case (op_i)
            OP_AND: alu_op_o = SL_AND;
            OP_OR:  alu_op_o = SL_OR;
            OP_ADD: begin
                alu_op_o   = SL_SUM;
                is_arith_o = 1'b1;
            end
            OP_SUB: begin
                binv_o     = 1'b1;
                alu_op_o   = SL_SUM;
                cin0_o     = 1'b1;
                is_arith_o = 1'b1;
            end
            OP_SLT: begin
                binv_o   = 1'b1;
                alu_op_o = SL_SUM;
                cin0_o   = 1'b1;
                is_slt_o = 1'b1;
            end
            OP_NOR: begin
                ainv_o   = 1'b1;
                binv_o   = 1'b1;
                alu_op_o = SL_AND;
            end
            default: is_rsvd_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_bit_serial_sequencer.sv
// Drives a shared 1-bit ALU slice LSB first over WIDTH cycles, chaining the
// carry through a register and assembling the result word and flags.
module alu_bit_serial_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    alu_bit_serial_sequencer_if.slave bus,
    output logic       alu_a_o,
    output logic       alu_b_o,
    output logic       alu_ainv_o,
    output logic       alu_binv_o,
    output logic [1:0] alu_op_o,
    output logic       alu_cin_o,
    output logic       alu_less_o,
    input  logic       alu_o_i,
    input  logic       alu_cout_i,
    input  logic       alu_set_i,
    input  logic       alu_ovf_i
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q, zero_q;

    logic             accept, running, last_bit;
    logic             req_ready, rsp_valid;
    logic [2:0]       dec_op;
    logic             d_ainv, d_binv, d_cin0, d_slt, d_arith, d_rsvd;
    logic [1:0]       d_aluop;
    logic [WIDTH-1:0] shifted, final_word;

    // In IDLE decode the incoming opcode (for cin0); otherwise the latched one.
    assign dec_op = (state_q == S_IDLE) ? bus.req_op : op_q;

    alu_seq_decode u_decode (
        .op_i       (dec_op),
        .ainv_o     (d_ainv),
        .binv_o     (d_binv),
        .alu_op_o   (d_aluop),
        .cin0_o     (d_cin0),
        .is_slt_o   (d_slt),
        .is_arith_o (d_arith),
        .is_rsvd_o  (d_rsvd)
    );

    assign shifted = {alu_o_i, shift_q[WIDTH-1:1]};

    // Final word: SLT keeps only the corrected sign, reserved ops yield zero.
    always_comb begin
        final_word = shifted;
        if (d_rsvd)
            final_word = '0;
        else if (d_slt)
            final_word = {{(WIDTH-1){1'b0}}, alu_set_i ^ alu_ovf_i};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state, handshakes and slice drive; slice outputs idle at 0 outside RUN.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        running    = 1'b0;
        last_bit   = 1'b0;
        alu_a_o    = 1'b0;
        alu_b_o    = 1'b0;
        alu_ainv_o = 1'b0;
        alu_binv_o = 1'b0;
        alu_op_o   = 2'b00;
        alu_cin_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                running    = 1'b1;
                alu_a_o    = a_q[cnt_q];
                alu_b_o    = b_q[cnt_q];
                alu_ainv_o = d_ainv;
                alu_binv_o = d_binv;
                alu_op_o   = d_aluop;
                alu_cin_o  = carry_q;
                if (cnt_q == LAST) begin
                    last_bit = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, bit counter, carry chain, shift register and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'd0;
            shift_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            op_q    <= bus.req_op;
            cnt_q   <= '0;
            carry_q <= d_cin0;
            shift_q <= '0;
        end else if (running) begin
            shift_q <= shifted;
            carry_q <= alu_cout_i;
            cnt_q   <= cnt_q + 1'b1;
            if (last_bit) begin
                result_q <= final_word;
                ovf_q    <= d_arith & alu_ovf_i;
                zero_q   <= (final_word == '0);
            end
        end
    end

    assign alu_less_o     = 1'b0;
    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = result_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// Directed bench for the bit-serial sequencer driving a behavioural 1-bit slice.
module tb_alu_bit_serial_sequencer;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] result;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_a, alu_b, alu_ainv, alu_binv, alu_cin, alu_less;
    logic [1:0] alu_op;
    logic alu_o, alu_cout, alu_set, alu_ovf;
    logic sa, sb, s_sum;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t sb_q[$];

    alu_bit_serial_sequencer_if #(.WIDTH(W)) bus ();

    alu_bit_serial_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_ainv_o (alu_ainv),
        .alu_binv_o (alu_binv),
        .alu_op_o   (alu_op),
        .alu_cin_o  (alu_cin),
        .alu_less_o (alu_less),
        .alu_o_i    (alu_o),
        .alu_cout_i (alu_cout),
        .alu_set_i  (alu_set),
        .alu_ovf_i  (alu_ovf)
    );

    // Behavioural 1-bit ALU slice.
    assign sa       = alu_a ^ alu_ainv;
    assign sb       = alu_b ^ alu_binv;
    assign s_sum    = sa ^ sb ^ alu_cin;
    assign alu_cout = (sa & sb) | (sa & alu_cin) | (sb & alu_cin);
    assign alu_set  = s_sum;
    assign alu_ovf  = alu_cin ^ alu_cout;
    assign alu_o    = (alu_op == 2'b00) ? (sa & sb) :
                      (alu_op == 2'b01) ? (sa | sb) :
                      (alu_op == 2'b10) ? s_sum : alu_less;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.result = '0;
        e.ovf    = 1'b0;
        case (op)
            3'd0: e.result = a & b;
            3'd1: e.result = a | b;
            3'd2: begin
                e.result = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.result[W-1] != a[W-1]);
            end
            3'd3: begin
                e.result = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.result[W-1] != a[W-1]);
            end
            3'd4: e.result = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd5: e.result = ~(a | b);
            default: e.result = '0;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " req_ready before start"}, 32'(bus.req_ready), 32'd1);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        accept_cyc    = cyc;
        bus.req_valid = 1'b0;
        sb_q.push_back(model(op, a, b));
    endtask

    task automatic finish_op(input string tag, input int hold);
        int n = 0;
        exp_t e;
        logic [W-1:0] r;
        logic o, z;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " latency"}, 32'(cyc - accept_cyc), 32'(W));
        r = bus.rsp_result;
        o = bus.rsp_ovf;
        z = bus.rsp_zero;
        bus.req_op    = 3'd2;
        bus.req_a     = 8'hFF;
        bus.req_b     = 8'hFF;
        bus.req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold result"}, 32'(bus.rsp_result), 32'(r));
            check({tag, " hold ovf"}, 32'(bus.rsp_ovf), 32'(o));
            check({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        check({tag, " scoreboard nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " result"}, 32'(bus.rsp_result), 32'(e.result));
            check({tag, " ovf"}, 32'(bus.rsp_ovf), 32'(e.ovf));
            check({tag, " zero"}, 32'(bus.rsp_zero), 32'(e.zero));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check({tag, " post valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int a1;
        logic seen;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset result", 32'(bus.rsp_result), 32'd0);
        check("reset ovf", 32'(bus.rsp_ovf), 32'd0);
        check("reset zero", 32'(bus.rsp_zero), 32'd0);
        check("idle slice drive", 32'({alu_a, alu_b, alu_ainv, alu_binv, alu_op, alu_cin}), 32'd0);

        start("add7f", 3'd2, 8'h7F, 8'h01);
        finish_op("add7f", 0);

        start("sub55", 3'd3, 8'h05, 8'h05);
        check("sub first binv", 32'(alu_binv), 32'd1);
        check("sub first cin", 32'(alu_cin), 32'd1);
        check("sub first op", 32'(alu_op), 32'd2);
        finish_op("sub55", 0);
        start("sub80", 3'd3, 8'h80, 8'h01);
        finish_op("sub80", 0);

        start("slt80_01", 3'd4, 8'h80, 8'h01);
        finish_op("slt80_01", 0);
        start("slt7f_80", 3'd4, 8'h7F, 8'h80);
        finish_op("slt7f_80", 0);
        start("slt03_03", 3'd4, 8'h03, 8'h03);
        finish_op("slt03_03", 0);

        start("and", 3'd0, 8'hF0, 8'h3C);
        finish_op("and", 0);
        start("or", 3'd1, 8'hF0, 8'h0F);
        finish_op("or", 0);
        start("nor", 3'd5, 8'hF0, 8'h0F);
        check("nor first ainv", 32'(alu_ainv), 32'd1);
        finish_op("nor", 0);
        start("op6", 3'd6, 8'hFF, 8'h01);
        finish_op("op6", 0);
        start("op7", 3'd7, 8'h12, 8'h34);
        finish_op("op7", 0);

        start("hold", 3'd2, 8'h12, 8'h34);
        finish_op("hold", 5);

        start("b2b_a", 3'd2, 8'h3C, 8'hC4);
        finish_op("b2b_a", 0);
        a1 = accept_cyc;
        start("b2b_b", 3'd3, 8'h10, 8'h20);
        check("b2b spacing", 32'(accept_cyc - a1), 32'(W + 2));
        finish_op("b2b_b", 0);

        start("rst_mid", 3'd2, 8'h55, 8'hAA);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("rst_mid req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid result", 32'(bus.rsp_result), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("rst_mid no emit", 32'(seen), 32'd0);
        start("after_rst", 3'd2, 8'h01, 8'h01);
        finish_op("after_rst", 0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
